// File: rtl/watch_time_ctrl_pkg.sv
// Shared mode encodings and BCD field limits for the watch time controller.
package watch_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HR   = 2'd1,
        SET_MIN  = 2'd2,
        MODE_INV = 2'd3
    } mode_t;

    localparam logic [7:0] HOUR_MAX = 8'h23;
    localparam logic [7:0] MIN_MAX  = 8'h59;
    localparam logic [7:0] SEC_MAX  = 8'h59;

endpackage

// File: rtl/watch_time_ctrl_if.sv
// Pulse inputs and display outputs of the watch time controller; slave = controller side.
interface watch_time_ctrl_if;

    logic        iEN_1;
    logic        iEN_200;
    logic        iBTN_MODE;
    logic        iBTN_UP;
    logic [15:0] oTIME_BCD;
    logic [3:0]  oBLANK;
    logic [1:0]  oMODE;
    logic        oCOLON;

    modport slave (
        input  iEN_1, iEN_200, iBTN_MODE, iBTN_UP,
        output oTIME_BCD, oBLANK, oMODE, oCOLON
    );

    modport master (
        output iEN_1, iEN_200, iBTN_MODE, iBTN_UP,
        input  oTIME_BCD, oBLANK, oMODE, oCOLON
    );

endinterface

// File: rtl/watch_time_ctrl_bcd2_inc.sv
// Combinational two-digit BCD increment; wraps to 00 and raises carry when value equals limit.
module bcd2_inc (
    input  logic [7:0] value,
    input  logic [7:0] limit,
    output logic [7:0] nxt,
    output logic       carry
);

    always_comb begin
        nxt   = value;
        carry = 1'b0;
        if (value == limit) begin
            nxt   = 8'h00;
            carry = 1'b1;
        end else if (value[3:0] == 4'd9) begin
            nxt = {value[7:4] + 4'd1, 4'd0};
        end else begin
            nxt = {value[7:4], value[3:0] + 4'd1};
        end
    end

endmodule

// File: rtl/watch_time_ctrl.sv
// HH:MM:SS watch controller with RUN / SET_HR / SET_MIN modes and registered outputs.
// Edited-digit blinking is built only when WATCH_BLINK_EN is defined; otherwise oBLANK is 0.
module watch_time_ctrl
    import watch_pkg::*;
#(
    parameter int BLINK_DIV = 100
) (
    input  logic            iCLK,
    input  logic            iRESET,
    watch_time_ctrl_if.slave io
);

    mode_t      mode_q, mode_n;
    logic [7:0] hr_q, min_q, sec_q;
    logic [7:0] hr_n, min_n, sec_n;
    logic       colon_q, colon_n;
    logic       up_ok;

    logic [7:0] sec_nx, min_nx, hr_nx;
    logic       sec_c, min_c;

    bcd2_inc u_sec_inc (.value(sec_q), .limit(SEC_MAX),  .nxt(sec_nx), .carry(sec_c));
    bcd2_inc u_min_inc (.value(min_q), .limit(MIN_MAX),  .nxt(min_nx), .carry(min_c));
    bcd2_inc u_hr_inc  (.value(hr_q),  .limit(HOUR_MAX), .nxt(hr_nx),  .carry());

    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            mode_q  <= RUN;
            hr_q    <= 8'h00;
            min_q   <= 8'h00;
            sec_q   <= 8'h00;
            colon_q <= 1'b0;
        end else begin
            mode_q  <= mode_n;
            hr_q    <= hr_n;
            min_q   <= min_n;
            sec_q   <= sec_n;
            colon_q <= colon_n;
        end
    end

    always_comb begin
        mode_n  = mode_q;
        hr_n    = hr_q;
        min_n   = min_q;
        sec_n   = sec_q;
        colon_n = colon_q;

        case (mode_q)
            RUN:     if (io.iBTN_MODE) mode_n = SET_HR;
            SET_HR:  if (io.iBTN_MODE) mode_n = SET_MIN;
            SET_MIN: if (io.iBTN_MODE) mode_n = RUN;
            default: mode_n = RUN;
        endcase

        // A mode press in the same cycle swallows the UP press.
        up_ok = io.iBTN_UP && !io.iBTN_MODE && (mode_q == SET_HR || mode_q == SET_MIN);

        if (mode_q == RUN && io.iEN_1) begin
            sec_n   = sec_nx;
            colon_n = ~colon_q;
            if (sec_c) begin
                min_n = min_nx;
                if (min_c) hr_n = hr_nx;
            end
        end

        if (up_ok && mode_q == SET_HR)  hr_n  = hr_nx;
        if (up_ok && mode_q == SET_MIN) min_n = min_nx;
        if (mode_q == SET_MIN && io.iBTN_MODE) sec_n = 8'h00;

        if (mode_n != RUN) colon_n = 1'b1;
    end

    assign io.oTIME_BCD = {hr_q, min_q};
    assign io.oMODE     = mode_q;
    assign io.oCOLON    = colon_q;

`ifdef WATCH_BLINK_EN
    localparam int BCW = $clog2(BLINK_DIV + 1);

    logic [BCW-1:0] blink_cnt;
    logic           blink_ph;
    logic           blink_restart;

    // Restart on any mode change or accepted edit so the edited pair is lit right after a press.
    assign blink_restart = (mode_n != mode_q) || up_ok;

    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
        end else if (blink_restart) begin
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
        end else if (io.iEN_200) begin
            if (blink_cnt == BCW'(BLINK_DIV - 1)) begin
                blink_cnt <= '0;
                blink_ph  <= ~blink_ph;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    assign io.oBLANK = !blink_ph            ? 4'b0000 :
                       (mode_q == SET_HR)   ? 4'b1100 :
                       (mode_q == SET_MIN)  ? 4'b0011 : 4'b0000;
`else
    assign io.oBLANK = 4'b0000;
`endif

endmodule

// File: tb/tb_watch_time_ctrl.sv
// Scoreboard bench: a seconds-of-day reference model predicts each cycle, a monitor compares.
module tb_watch_time_ctrl;

    localparam int BLINK_DIV = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    watch_time_ctrl_if io ();

    watch_time_ctrl #(.BLINK_DIV(BLINK_DIV)) dut (
        .iCLK  (clk),
        .iRESET(rst),
        .io    (io.slave)
    );

    typedef struct packed {
        logic [15:0] t;
        logic [3:0]  b;
        logic [1:0]  m;
        logic        c;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference state: plain integers, converted to BCD only for comparison.
    int m_h, m_m, m_s, m_mode, m_bcnt;
    bit m_colon, m_ph;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] bcd8(input int v);
        logic [3:0] hi, lo;
        hi = 4'(v / 10);
        lo = 4'(v % 10);
        return {hi, lo};
    endfunction

    task automatic model_reset();
        m_h = 0; m_m = 0; m_s = 0; m_mode = 0; m_bcnt = 0;
        m_colon = 1'b0; m_ph = 1'b0;
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.t = {bcd8(m_h), bcd8(m_m)};
        e.m = 2'(m_mode);
        e.c = m_colon;
        e.b = 4'b0000;
`ifdef WATCH_BLINK_EN
        if (m_ph && m_mode == 1) e.b = 4'b1100;
        if (m_ph && m_mode == 2) e.b = 4'b0011;
`endif
        return e;
    endfunction

    task automatic model_step(input bit e1, input bit e200, input bit bm, input bit bu);
        int  day;
        bit  acc;
        acc = bu && !bm && (m_mode != 0);
        if (m_mode == 0 && e1) begin
            day = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
            m_h = day / 3600; m_m = (day / 60) % 60; m_s = day % 60;
            m_colon = ~m_colon;
        end
        if (acc && m_mode == 1) m_h = (m_h + 1) % 24;
        if (acc && m_mode == 2) m_m = (m_m + 1) % 60;
        if (bm) begin
            if (m_mode == 2) m_s = 0;
            m_mode = (m_mode + 1) % 3;
        end
        if (m_mode != 0) m_colon = 1'b1;
        if (bm || acc) begin
            m_bcnt = 0; m_ph = 1'b0;
        end else if (e200) begin
            m_bcnt++;
            if (m_bcnt == BLINK_DIV) begin
                m_bcnt = 0; m_ph = ~m_ph;
            end
        end
    endtask

    task automatic step(input bit e1, input bit e200, input bit bm, input bit bu);
        @(negedge clk);
        io.iEN_1 = e1; io.iEN_200 = e200; io.iBTN_MODE = bm; io.iBTN_UP = bu;
        model_step(e1, e200, bm, bu);
        q.push_back(model_out());
    endtask

    // One quiet cycle, then leaves the caller just after the edge for direct checks.
    task automatic settle();
        step(0, 0, 0, 0);
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!rst && q.size() > 0) begin
            e = q.pop_front();
            chk("sb_time",  32'(io.oTIME_BCD), 32'(e.t));
            chk("sb_blank", 32'(io.oBLANK),    32'(e.b));
            chk("sb_mode",  32'(io.oMODE),     32'(e.m));
            chk("sb_colon", 32'(io.oCOLON),    32'(e.c));
        end
    end

    initial begin
        io.iEN_1 = 0; io.iEN_200 = 0; io.iBTN_MODE = 0; io.iBTN_UP = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_time",  32'(io.oTIME_BCD), 32'h0000);
        chk("rst_mode",  32'(io.oMODE),     32'd0);
        chk("rst_blank", 32'(io.oBLANK),    32'd0);
        chk("rst_colon", 32'(io.oCOLON),    32'd0);
        rst = 1'b0;

        // 60 seconds roll one minute; colon ends back low.
        for (int i = 0; i < 60; i++) begin
            step(1, 0, 0, 0);
            if (i % 3 == 0) step(0, 0, 0, 0);
        end
        settle();
        chk("sec_wrap_time",  32'(io.oTIME_BCD), 32'h0001);
        chk("sec_wrap_colon", 32'(io.oCOLON),    32'd0);

        // Preload 23:59, run 59 s, then midnight rollover.
        step(0, 0, 1, 0);
        for (int i = 0; i < 23; i++) step(0, 0, 0, 1);
        step(0, 0, 1, 0);
        for (int i = 0; i < 58; i++) step(0, 0, 0, 1);
        step(0, 0, 1, 0);
        for (int i = 0; i < 59; i++) step(1, 0, 0, 0);
        settle();
        chk("preload_time", 32'(io.oTIME_BCD), 32'h2359);
        step(1, 0, 0, 0);
        settle();
        chk("midnight_time", 32'(io.oTIME_BCD), 32'h0000);

        // Hour set wraps after 24 presses; minute set wraps after 60 without touching hours.
        step(0, 0, 1, 0);
        for (int i = 0; i < 24; i++) step(0, 0, 0, 1);
        settle();
        chk("hr_wrap_time", 32'(io.oTIME_BCD), 32'h0000);
        chk("hr_mode",      32'(io.oMODE),     32'd1);
        chk("set_colon",    32'(io.oCOLON),    32'd1);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1);
        step(0, 0, 1, 0);
        for (int i = 0; i < 60; i++) step(0, 0, 0, 1);
        settle();
        chk("min_wrap_time", 32'(io.oTIME_BCD), 32'h0500);
        chk("min_mode",      32'(io.oMODE),     32'd2);

        // Mode and UP together in SET_HR: mode wins.
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 1);
        settle();
        chk("mode_up_mode", 32'(io.oMODE),     32'd2);
        chk("mode_up_time", 32'(io.oTIME_BCD), 32'h0500);

        // Blink in SET_MIN at the default divider.
        for (int i = 0; i < 99; i++) step(0, 1, 0, 0);
        settle();
        chk("blink_99", 32'(io.oBLANK), 32'b0000);
        step(0, 1, 0, 0);
        settle();
`ifdef WATCH_BLINK_EN
        chk("blink_100", 32'(io.oBLANK), 32'b0011);
`else
        chk("blink_100", 32'(io.oBLANK), 32'b0000);
`endif
        for (int i = 0; i < 100; i++) step(0, 1, 0, 0);
        settle();
        chk("blink_200", 32'(io.oBLANK), 32'b0000);
        for (int i = 0; i < 100; i++) step(0, 1, 0, 0);
        step(0, 1, 0, 1);
        settle();
        chk("blink_up_lit", 32'(io.oBLANK), 32'b0000);
        for (int i = 0; i < 99; i++) step(0, 1, 0, 0);
        settle();
        chk("blink_up_99", 32'(io.oBLANK), 32'b0000);

        // Random traffic against the reference model.
        for (int i = 0; i < 3000; i++)
            step($urandom_range(3) == 0, $urandom_range(1) == 0,
                 $urandom_range(19) == 0, $urandom_range(3) == 0);

        // Asynchronous reset in the middle of an hour edit.
        while (m_mode != 1) step(0, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
        settle();
        #1 rst = 1'b1;
        #1;
        chk("arst_mode",  32'(io.oMODE),     32'd0);
        chk("arst_time",  32'(io.oTIME_BCD), 32'h0000);
        chk("arst_blank", 32'(io.oBLANK),    32'd0);
        chk("arst_colon", 32'(io.oCOLON),    32'd0);
        q.delete();
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 300; i++)
            step($urandom_range(3) == 0, $urandom_range(1) == 0,
                 $urandom_range(15) == 0, $urandom_range(2) == 0);

        step(0, 0, 0, 0);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        #3;
        chk("drain_empty", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
